// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: serial-subtractor state encodings and full-subtractor cell equations.
// No logic of its own; the helper functions are pure combinational expressions.
package arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam string FS_DIFF_EQ = "d  = a ^ b ^ bin";
    localparam string FS_BOUT_EQ = "bo = (~a & b) | (~(a ^ b) & bin)";

    function automatic logic fs_diff(input logic a, input logic b, input logic bin);
        return a ^ b ^ bin;
    endfunction

    function automatic logic fs_bout(input logic a, input logic b, input logic bin);
        return (~a & b) | (~(a ^ b) & bin);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: diff = a - b - bin, bout set when the bit borrows.
// Purely combinational, zero latency, no handshake.
module full_subtractor
    import arith_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = fs_diff(a, b, bin);
    assign bout = fs_bout(a, b, bin);

endmodule

// File: rtl/bit_serial_subtractor.sv
// LSB-first serial subtractor: {bout,diff} = a - b - bin over WIDTH RUN cycles, result after WIDTH edges.
// in_ready only in IDLE; result held in DONE until out_ready, no overlap of operations.
module bit_serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_diff_sr;
    logic             r_br;
    logic [CNT_W-1:0] r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;

    logic             w_d;
    logic             w_bo;
    logic [WIDTH-1:0] w_diff_next;

    full_subtractor u_cell (
        .a    (r_a_sr[0]),
        .b    (r_b_sr[0]),
        .bin  (r_br),
        .diff (w_d),
        .bout (w_bo)
    );

    // Result bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    generate
        if (WIDTH == 1) begin : g_w1
            assign w_diff_next = w_d;
        end else begin : g_wn
            assign w_diff_next = {w_d, r_diff_sr[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_a_sr      <= '0;
            r_b_sr      <= '0;
            r_diff_sr   <= '0;
            r_br        <= 1'b0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_diff      <= '0;
            r_bout      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a_sr     <= a;
                        r_b_sr     <= b;
                        r_br       <= bin;
                        r_cnt      <= '0;
                        r_state    <= ST_RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_a_sr    <= r_a_sr >> 1;
                    r_b_sr    <= r_b_sr >> 1;
                    r_diff_sr <= w_diff_next;
                    r_br      <= w_bo;
                    r_cnt     <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_BIT) begin
                        r_state     <= ST_DONE;
                        r_diff      <= w_diff_next;
                        r_bout      <= w_bo;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign diff      = r_diff;
    assign bout      = r_bout;

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Self-checking bench for bit_serial_subtractor: WIDTH=8 vectors and corner sequences,
// plus exhaustive WIDTH=4 and WIDTH=1 sweeps against a scoreboard.
module tb_bit_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int   sel = 0;
    logic [7:0] a_d = '0, b_d = '0;
    logic bin_d = 1'b0, in_valid_d = 1'b0, out_ready_d = 1'b0;

    logic       rdy8, ov8, bout8, busy8;
    logic [7:0] diff8;
    logic       rdy4, ov4, bout4, busy4;
    logic [3:0] diff4;
    logic       rdy1, ov1, bout1, busy1;
    logic [0:0] diff1;

    bit_serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_d && sel == 0), .in_ready(rdy8),
        .a(a_d), .b(b_d), .bin(bin_d), .out_valid(ov8), .out_ready(out_ready_d && sel == 0),
        .diff(diff8), .bout(bout8), .busy(busy8));

    bit_serial_subtractor #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_d && sel == 1), .in_ready(rdy4),
        .a(a_d[3:0]), .b(b_d[3:0]), .bin(bin_d), .out_valid(ov4), .out_ready(out_ready_d && sel == 1),
        .diff(diff4), .bout(bout4), .busy(busy4));

    bit_serial_subtractor #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_d && sel == 2), .in_ready(rdy1),
        .a(a_d[0:0]), .b(b_d[0:0]), .bin(bin_d), .out_valid(ov1), .out_ready(out_ready_d && sel == 2),
        .diff(diff1), .bout(bout1), .busy(busy1));

    logic       m_in_ready, m_out_valid, m_bout, m_busy;
    logic [7:0] m_diff;
    int         m_w;
    always_comb begin
        m_in_ready = rdy8; m_out_valid = ov8; m_bout = bout8; m_busy = busy8; m_diff = diff8; m_w = 8;
        case (sel)
            1: begin m_in_ready = rdy4; m_out_valid = ov4; m_bout = bout4; m_busy = busy4;
                     m_diff = {4'b0, diff4}; m_w = 4; end
            2: begin m_in_ready = rdy1; m_out_valid = ov1; m_bout = bout1; m_busy = busy1;
                     m_diff = {7'b0, diff1}; m_w = 1; end
            default: ;
        endcase
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: {bout,diff} = {1'b0,a} - b - bin, restricted to the active width.
    function automatic logic [8:0] model(input int w, input logic [7:0] a, input logic [7:0] b, input logic bi);
        logic [7:0] mask;
        logic [8:0] full;
        mask = 8'((1 << w) - 1);
        full = {1'b0, a & mask} - {1'b0, b & mask} - {8'b0, bi};
        return {full[8], full[7:0] & mask};
    endfunction

    logic [8:0] sb[$];
    int n_res = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid_d && m_in_ready)
                sb.push_back(model(m_w, a_d, b_d, bin_d));
            if (m_out_valid && out_ready_d) begin
                n_res++;
                if (sb.size() == 0) chk("scoreboard_underflow", 32'd1, 32'd0);
                else                chk("scoreboard", {23'b0, m_bout, m_diff}, {23'b0, sb.pop_front()});
            end
        end
    end

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic bi,
                         output int lat, output logic [8:0] res);
        int k, t0;
        @(posedge clk); #1;
        a_d = a; b_d = b; bin_d = bi; in_valid_d = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!m_in_ready && k < 30);
        chk("in_ready_wait", {31'b0, m_in_ready}, 32'd1);
        @(posedge clk); #1;
        t0 = cyc;
        in_valid_d = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!m_out_valid && k < 40);
        chk("out_valid_wait", {31'b0, m_out_valid}, 32'd1);
        lat = cyc - t0;
        res = {m_bout, m_diff};
    endtask

    task automatic stream(input int w, input int n, input bit exh);
        int k, last, base;
        logic [7:0] mask;
        mask = 8'((1 << w) - 1);
        base = n_res;
        last = 0;
        out_ready_d = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            if (exh) begin
                a_d = 8'(i >> (w + 1)) & mask;
                b_d = 8'(i >> 1) & mask;
                bin_d = i[0];
            end else begin
                a_d = 8'($urandom) & mask;
                b_d = 8'($urandom) & mask;
                bin_d = 1'($urandom);
            end
            in_valid_d = 1'b1;
            k = 0;
            do begin @(negedge clk); k++; end while (!m_in_ready && k < 30);
            @(posedge clk); #1;
            if (i > 0) chk($sformatf("interval_w%0d_%0d", w, i), 32'(cyc - last), 32'(w + 2));
            last = cyc;
        end
        in_valid_d = 1'b0;
        k = 0;
        while ((n_res - base) < n && k < 40) begin @(negedge clk); #1; k++; end
        chk($sformatf("stream_count_w%0d", w), 32'(n_res - base), 32'(n));
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bi;
        logic [7:0] d;
        logic       bo;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int lat;
        logic [8:0] res, held;

        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
        vecs[2] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0};
        vecs[3] = '{8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0};
        vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[6] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};
        vecs[7] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
        vecs[8] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1};

        #12;
        chk("rst_in_ready",  {31'b0, rdy8},  32'd1);
        chk("rst_out_valid", {31'b0, ov8},   32'd0);
        chk("rst_busy",      {31'b0, busy8}, 32'd0);
        chk("rst_diff",      {24'b0, diff8}, 32'd0);
        chk("rst_bout",      {31'b0, bout8}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        out_ready_d = 1'b1;
        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].bi, lat, res);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd8);
            chk($sformatf("vec%0d_result", i), {23'b0, res}, {23'b0, vecs[i].bo, vecs[i].d});
            chk($sformatf("vec%0d_busy_done", i), {31'b0, m_busy}, 32'd1);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_single_valid", i), {31'b0, m_out_valid}, 32'd0);
            chk($sformatf("vec%0d_back_idle", i), {31'b0, m_in_ready}, 32'd1);
        end

        // Hold the result in DONE while in_valid pulses must be ignored.
        out_ready_d = 1'b0;
        do_op(8'h3C, 8'h0F, 1'b0, lat, res);
        held = res;
        chk("bp_result", {23'b0, held}, 32'h02D);
        for (int j = 0; j < 5; j++) begin
            @(posedge clk); #1;
            in_valid_d = (j % 2 == 0);
            a_d = 8'($urandom);
            @(negedge clk);
            chk($sformatf("bp_hold_%0d", j), {23'b0, m_bout, m_diff}, {23'b0, held});
            chk($sformatf("bp_in_ready_%0d", j), {31'b0, m_in_ready}, 32'd0);
            chk($sformatf("bp_out_valid_%0d", j), {31'b0, m_out_valid}, 32'd1);
        end
        @(posedge clk); #1;
        in_valid_d = 1'b0;
        out_ready_d = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_idle", {31'b0, m_in_ready}, 32'd1);
        chk("bp_release_valid", {31'b0, m_out_valid}, 32'd0);
        chk("bp_no_extra_accept", 32'(sb.size()), 32'd0);

        // Reset while cnt==3 in RUN.
        @(posedge clk); #1;
        a_d = 8'h12; b_d = 8'h34; bin_d = 1'b0; in_valid_d = 1'b1;
        @(negedge clk);
        chk("mid_pre_ready", {31'b0, m_in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid_d = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'b0, ov8},   32'd0);
        chk("mid_rst_in_ready",  {31'b0, rdy8},  32'd1);
        chk("mid_rst_busy",      {31'b0, busy8}, 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        do_op(8'hA5, 8'h5A, 1'b0, lat, res);
        chk("post_rst_result", {23'b0, res}, 32'h04B);
        chk("post_rst_latency", 32'(lat), 32'd8);
        @(posedge clk); #1;

        stream(8, 12, 1'b0);
        sel = 1;
        stream(4, 512, 1'b1);
        sel = 2;
        stream(1, 8, 1'b1);

        chk("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
